// File: rtl/speicher_zugriff.sv
// Load/store unit: byte/half/word access to a word RAM, sub-word stores as read-modify-write.
// Latency (zero-wait RAM, edges after accept): word access 3, sub-word store 5, accept error 1.
// Backpressure: one access in flight; Start is ignored while busy and in the Fertig cycle.
module speicher_zugriff #(
  parameter int WORDSIZE = 32,
  parameter int WORDS    = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Schreiben,
  input  logic [1:0]          Breite,
  input  logic                Vorzeichen,
  input  logic [WORDSIZE-1:0] CpuAdresse,
  input  logic [WORDSIZE-1:0] CpuDatenRein,
  output logic [WORDSIZE-1:0] CpuDatenRaus,
  output logic                Fertig,
  output logic                Fehler,
  output logic                Beschaeftigt,
  output logic                RamLesenAn,
  output logic                RamSchreibenAn,
  output logic [WORDSIZE-1:0] RamAdresse,
  output logic [WORDSIZE-1:0] RamDatenRein,
  input  logic [WORDSIZE-1:0] RamDatenRaus,
  input  logic                RamDatenBereit,
  input  logic                RamDatenGeschrieben
);

  // Width of the acknowledge wait counter; it must hold TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]       LP_LETZTER = CW'(TIMEOUT - 1);
  localparam logic [WORDSIZE-1:0] LP_WORDS   = WORDSIZE'(WORDS);

  localparam logic [1:0] BR_BYTE = 2'b00;
  localparam logic [1:0] BR_HALB = 2'b01;
  localparam logic [1:0] BR_WORT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LESEN,
    S_LESEN_WARTEN,
    S_SCHREIBEN,
    S_SCHREIBEN_WARTEN,
    S_ENDE
  } state_t;

  state_t r_state;

  // Request latched at accept; only the bits used later are kept.
  logic                r_schreiben;
  logic [1:0]          r_breite;
  logic                r_vorzeichen;
  logic [1:0]          r_lane;
  logic [15:0]         r_daten;
  logic                r_fehler_int;
  logic [WORDSIZE-1:0] r_ergebnis;
  logic [CW-1:0]       r_warten;

  // Registered outputs.
  logic [WORDSIZE-1:0] r_daten_raus;
  logic                r_fertig;
  logic                r_fehler;
  logic                r_busy;
  logic                r_ram_lesen;
  logic                r_ram_schreiben;
  logic [WORDSIZE-1:0] r_ram_adresse;
  logic [WORDSIZE-1:0] r_ram_daten;

  // Accept-time checks on the raw request.
  logic                w_fehlausrichtung;
  logic                w_ausser_bereich;
  logic [WORDSIZE-1:0] w_wortadresse;

  // Lane extraction/merge on the RAM read word.
  logic [7:0]          w_byte;
  logic [15:0]         w_halb;
  logic [WORDSIZE-1:0] w_geladen;
  logic [WORDSIZE-1:0] w_gemischt;

  assign w_wortadresse = {2'b00, CpuAdresse[WORDSIZE-1:2]};

  // Classify the incoming request: illegal width, misalignment, or beyond the RAM depth.
  always_comb begin
    w_fehlausrichtung = 1'b0;
    case (Breite)
      BR_BYTE: w_fehlausrichtung = 1'b0;
      BR_HALB: w_fehlausrichtung = CpuAdresse[0];
      BR_WORT: w_fehlausrichtung = (CpuAdresse[1:0] != 2'b00);
      default: w_fehlausrichtung = 1'b1;
    endcase
    w_ausser_bereich = (w_wortadresse >= LP_WORDS);
  end

  // Select the addressed lane of the read word and sign- or zero-extend it.
  always_comb begin
    w_byte = RamDatenRaus[7:0];
    case (r_lane)
      2'd0:    w_byte = RamDatenRaus[7:0];
      2'd1:    w_byte = RamDatenRaus[15:8];
      2'd2:    w_byte = RamDatenRaus[23:16];
      default: w_byte = RamDatenRaus[31:24];
    endcase
    w_halb    = r_lane[1] ? RamDatenRaus[31:16] : RamDatenRaus[15:0];
    w_geladen = RamDatenRaus;
    case (r_breite)
      BR_BYTE: w_geladen = {{24{r_vorzeichen & w_byte[7]}}, w_byte};
      BR_HALB: w_geladen = {{16{r_vorzeichen & w_halb[15]}}, w_halb};
      default: w_geladen = RamDatenRaus;
    endcase
  end

  // Overlay the stored byte/half onto the word just read, leaving the other lanes intact.
  always_comb begin
    w_gemischt = RamDatenRaus;
    if (r_breite == BR_BYTE) begin
      case (r_lane)
        2'd0:    w_gemischt[7:0]   = r_daten[7:0];
        2'd1:    w_gemischt[15:8]  = r_daten[7:0];
        2'd2:    w_gemischt[23:16] = r_daten[7:0];
        default: w_gemischt[31:24] = r_daten[7:0];
      endcase
    end else if (r_breite == BR_HALB) begin
      if (r_lane[1]) begin
        w_gemischt[31:16] = r_daten;
      end else begin
        w_gemischt[15:0] = r_daten;
      end
    end
  end

  // Access sequencer; strobes, Fertig and the load result are one-cycle registered pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_schreiben     <= 1'b0;
      r_breite        <= 2'b00;
      r_vorzeichen    <= 1'b0;
      r_lane          <= 2'b00;
      r_daten         <= '0;
      r_fehler_int    <= 1'b0;
      r_ergebnis      <= '0;
      r_warten        <= '0;
      r_daten_raus    <= '0;
      r_fertig        <= 1'b0;
      r_fehler        <= 1'b0;
      r_busy          <= 1'b0;
      r_ram_lesen     <= 1'b0;
      r_ram_schreiben <= 1'b0;
      r_ram_adresse   <= '0;
      r_ram_daten     <= '0;
    end else begin
      r_fertig        <= 1'b0;
      r_fehler        <= 1'b0;
      r_daten_raus    <= '0;
      r_ram_lesen     <= 1'b0;
      r_ram_schreiben <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // The Fertig cycle is spent in IDLE; a new request is taken one cycle later.
          if (Start && !r_fertig) begin
            r_schreiben  <= Schreiben;
            r_breite     <= Breite;
            r_vorzeichen <= Vorzeichen;
            r_lane       <= CpuAdresse[1:0];
            r_daten      <= CpuDatenRein[15:0];
            r_ergebnis   <= '0;
            r_busy       <= 1'b1;
            if (w_fehlausrichtung || w_ausser_bereich) begin
              r_fehler_int <= 1'b1;
              r_state      <= S_ENDE;
            end else begin
              r_fehler_int  <= 1'b0;
              r_ram_adresse <= w_wortadresse;
              if (Schreiben && (Breite == BR_WORT)) begin
                r_ram_schreiben <= 1'b1;
                r_ram_daten     <= CpuDatenRein;
                r_state         <= S_SCHREIBEN;
              end else begin
                r_ram_lesen <= 1'b1;
                r_state     <= S_LESEN;
              end
            end
          end
        end

        S_LESEN: begin
          r_warten <= '0;
          r_state  <= S_LESEN_WARTEN;
        end

        S_LESEN_WARTEN: begin
          if (RamDatenBereit) begin
            if (r_schreiben) begin
              r_ram_daten     <= w_gemischt;
              r_ram_schreiben <= 1'b1;
              r_state         <= S_SCHREIBEN;
            end else begin
              r_ergebnis <= w_geladen;
              r_state    <= S_ENDE;
            end
          end else if (r_warten == LP_LETZTER) begin
            r_fehler_int <= 1'b1;
            r_state      <= S_ENDE;
          end else begin
            r_warten <= r_warten + CW'(1);
          end
        end

        S_SCHREIBEN: begin
          r_warten <= '0;
          r_state  <= S_SCHREIBEN_WARTEN;
        end

        S_SCHREIBEN_WARTEN: begin
          if (RamDatenGeschrieben) begin
            r_state <= S_ENDE;
          end else if (r_warten == LP_LETZTER) begin
            r_fehler_int <= 1'b1;
            r_state      <= S_ENDE;
          end else begin
            r_warten <= r_warten + CW'(1);
          end
        end

        S_ENDE: begin
          r_fertig     <= 1'b1;
          r_fehler     <= r_fehler_int;
          r_daten_raus <= (r_fehler_int || r_schreiben) ? '0 : r_ergebnis;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign CpuDatenRaus   = r_daten_raus;
  assign Fertig         = r_fertig;
  assign Fehler         = r_fehler;
  assign Beschaeftigt   = r_busy;
  assign RamLesenAn     = r_ram_lesen;
  assign RamSchreibenAn = r_ram_schreiben;
  assign RamAdresse     = r_ram_adresse;
  assign RamDatenRein   = r_ram_daten;

endmodule

// File: tb/tb_speicher_zugriff.sv
// Bench for speicher_zugriff: directed accesses against a small RAM model.
// Expected responses are queued at issue and compared by a monitor on each Fertig pulse.
// Side checks (strobe counts, RAM contents, reset values) go through the same monitor.
module tb_speicher_zugriff;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic        Schreiben;
  logic [1:0]  Breite;
  logic        Vorzeichen;
  logic [31:0] CpuAdresse;
  logic [31:0] CpuDatenRein;
  logic [31:0] CpuDatenRaus;
  logic        Fertig;
  logic        Fehler;
  logic        Beschaeftigt;
  logic        RamLesenAn;
  logic        RamSchreibenAn;
  logic [31:0] RamAdresse;
  logic [31:0] RamDatenRein;
  logic [31:0] ram_raus;
  logic        mdl_bereit;
  logic        man_bereit;
  logic        mdl_geschr;
  logic        ram_bereit;

  assign ram_bereit = mdl_bereit | man_bereit;

  speicher_zugriff #(.WORDSIZE(32), .WORDS(32), .TIMEOUT(TIMEOUT)) dut (
    .Clock              (clk),
    .Reset              (Reset),
    .Start              (Start),
    .Schreiben          (Schreiben),
    .Breite             (Breite),
    .Vorzeichen         (Vorzeichen),
    .CpuAdresse         (CpuAdresse),
    .CpuDatenRein       (CpuDatenRein),
    .CpuDatenRaus       (CpuDatenRaus),
    .Fertig             (Fertig),
    .Fehler             (Fehler),
    .Beschaeftigt       (Beschaeftigt),
    .RamLesenAn         (RamLesenAn),
    .RamSchreibenAn     (RamSchreibenAn),
    .RamAdresse         (RamAdresse),
    .RamDatenRein       (RamDatenRein),
    .RamDatenRaus       (ram_raus),
    .RamDatenBereit     (ram_bereit),
    .RamDatenGeschrieben(mdl_geschr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int zyklus = 0;
  always @(posedge clk) zyklus <= zyklus + 1;

  typedef struct {
    string       name;
    logic [31:0] daten;
    logic        fehler;
    int          lat;
    int          t0;
  } erw_t;

  typedef struct {
    string       name;
    logic [31:0] ist;
    logic [31:0] soll;
  } chk_t;

  erw_t sq[$];
  chk_t cq[$];

  int errors = 0;
  int checks = 0;
  int fertig_zahl = 0;
  int fz_alt = 0;

  // RAM model state and controls
  logic [31:0] mem [32];
  int          les_zahl = 0;
  int          sch_zahl = 0;
  logic [31:0] les_adr = '0;
  logic [31:0] sch_adr = '0;
  int          ram_wait = 0;
  bit          ram_an = 1'b1;

  // RAM model: sees strobes mid-cycle, answers after ram_wait further edges.
  initial begin
    int  les_rest;
    int  sch_rest;
    bit  les_aktiv;
    bit  sch_aktiv;
    les_rest = 0; sch_rest = 0; les_aktiv = 1'b0; sch_aktiv = 1'b0;
    mdl_bereit = 1'b0; mdl_geschr = 1'b0; ram_raus = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (RamLesenAn) begin
        les_zahl++;
        les_adr   = RamAdresse;
        les_rest  = ram_wait;
        les_aktiv = ram_an;
      end
      if (RamSchreibenAn) begin
        sch_zahl++;
        sch_adr   = RamAdresse;
        mem[RamAdresse[4:0]] = RamDatenRein;
        sch_rest  = ram_wait;
        sch_aktiv = ram_an;
      end
      @(posedge clk);
      #1;
      mdl_bereit = 1'b0;
      mdl_geschr = 1'b0;
      if (les_aktiv) begin
        if (les_rest == 0) begin
          mdl_bereit = 1'b1;
          ram_raus   = mem[les_adr[4:0]];
          les_aktiv  = 1'b0;
        end else les_rest--;
      end
      if (sch_aktiv) begin
        if (sch_rest == 0) begin
          mdl_geschr = 1'b1;
          sch_aktiv  = 1'b0;
        end else sch_rest--;
      end
    end
  end

  task automatic vergleiche(input string name, input logic [31:0] ist, input logic [31:0] soll);
    checks++;
    if (ist !== soll) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, ist, soll);
    end
  endtask

  // Monitor: drains side checks, then scores every Fertig pulse against the queue.
  always @(negedge clk) begin
    chk_t c;
    erw_t e;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      vergleiche(c.name, c.ist, c.soll);
    end
    if (Fertig) begin
      fertig_zahl++;
      if (sq.size() == 0) begin
        vergleiche("unexpected_fertig", 32'd1, 32'd0);
      end else begin
        e = sq.pop_front();
        vergleiche({e.name, "_data"}, CpuDatenRaus, e.daten);
        vergleiche({e.name, "_fehler"}, {31'd0, Fehler}, {31'd0, e.fehler});
        vergleiche({e.name, "_latency"}, 32'(zyklus - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
    chk_t c;
    c.name = name; c.ist = ist; c.soll = soll;
    cq.push_back(c);
  endtask

  task automatic zugriff(input string name, input logic w, input logic [1:0] b, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic ef, input int el, input bit erw);
    erw_t e;
    fz_alt       = fertig_zahl;
    Schreiben    = w;
    Breite       = b;
    Vorzeichen   = s;
    CpuAdresse   = a;
    CpuDatenRein = d;
    Start        = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    if (erw) begin
      e.name = name; e.daten = ed; e.fehler = ef; e.lat = el; e.t0 = zyklus;
      sq.push_back(e);
    end
  endtask

  task automatic warte(input string name);
    int n;
    n = 0;
    while (fertig_zahl == fz_alt && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (fertig_zahl == fz_alt) pruefe({name, "_no_fertig"}, 32'd0, 32'd1);
  endtask

  task automatic op(input string name, input logic w, input logic [1:0] b, input logic s,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] ed, input logic ef, input int el);
    zugriff(name, w, b, s, a, d, ed, ef, el, 1'b1);
    warte(name);
  endtask

  task automatic pruefe_alles_null(input string name);
    pruefe({name, "_daten"}, CpuDatenRaus, 32'd0);
    pruefe({name, "_flags"}, {27'd0, Fertig, Fehler, Beschaeftigt, RamLesenAn, RamSchreibenAn}, 32'd0);
    pruefe({name, "_ramadr"}, RamAdresse, 32'd0);
    pruefe({name, "_ramdat"}, RamDatenRein, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_les;
    int n_sch;
    int n_f;
    Reset = 1'b1; Start = 1'b0; Schreiben = 1'b0; Breite = 2'b00; Vorzeichen = 1'b0;
    CpuAdresse = '0; CpuDatenRein = '0; man_bereit = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    pruefe_alles_null("reset");
    Reset = 1'b0;
    @(posedge clk);
    #2;

    // T1: word store then word load
    op("t1_store", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
    pruefe("t1_store_adr", sch_adr, 32'd2);
    op("t1_load", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    pruefe("t1_load_adr", les_adr, 32'd2);

    // T2: sub-word read-modify-write and extension
    op("t2_init", 1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 32'h0, 1'b0, 3);
    op("t2_sb", 1'b1, 2'b00, 1'b0, 32'h2, 32'hFFFF_FFAB, 32'h0, 1'b0, 5);
    pruefe("t2_ram_sb", mem[0], 32'h11AB_3344);
    op("t2_lb_s", 1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 32'hFFFF_FFAB, 1'b0, 3);
    op("t2_lb_u", 1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 32'h0000_00AB, 1'b0, 3);
    op("t2_lh_u", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'h0000_11AB, 1'b0, 3);
    op("t2_lh_s0", 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h0000_3344, 1'b0, 3);
    op("t2_sh", 1'b1, 2'b01, 1'b0, 32'h2, 32'h1234_BEEF, 32'h0, 1'b0, 5);
    pruefe("t2_ram_sh", mem[0], 32'hBEEF_3344);
    op("t2_lh_s2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'hFFFF_BEEF, 1'b0, 3);
    op("t2_lb_s3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'hFFFF_FFBE, 1'b0, 3);
    op("t2_lb_u1", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h0000_0033, 1'b0, 3);
    op("t2_lw_s", 1'b0, 2'b10, 1'b1, 32'h0, 32'h0, 32'hBEEF_3344, 1'b0, 3);

    // T3: misaligned and illegal width, no RAM traffic
    n_les = les_zahl;
    n_sch = sch_zahl;
    op("t3_lh3", 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1, 1);
    op("t3_lw6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    op("t3_br11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    op("t3_sw5", 1'b1, 2'b10, 1'b0, 32'h5, 32'h5555_5555, 32'h0, 1'b1, 1);
    pruefe("t3_reads", 32'(les_zahl), 32'(n_les));
    pruefe("t3_writes", 32'(sch_zahl), 32'(n_sch));

    // T4: range boundary and acknowledge timeout
    op("t4_sw31", 1'b1, 2'b10, 1'b0, 32'h7C, 32'hA5A5_0F0F, 32'h0, 1'b0, 3);
    op("t4_lw31", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'hA5A5_0F0F, 1'b0, 3);
    n_les = les_zahl;
    op("t4_lw32", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1);
    pruefe("t4_range_reads", 32'(les_zahl), 32'(n_les));
    ram_an = 1'b0;
    n_sch  = sch_zahl;
    op("t4_lw_to", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, TIMEOUT + 2);
    op("t4_sb_to", 1'b1, 2'b00, 1'b0, 32'h1, 32'h77, 32'h0, 1'b1, TIMEOUT + 2);
    pruefe("t4_to_writes", 32'(sch_zahl), 32'(n_sch));

    // T5: reset in LESEN_WARTEN, late acknowledge ignored
    n_f = fertig_zahl;
    zugriff("t5_abort", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    pruefe("t5_busy_before", {31'd0, Beschaeftigt}, 32'd1);
    Reset = 1'b1;
    @(posedge clk);
    #2;
    pruefe_alles_null("t5_reset");
    Reset = 1'b0;
    man_bereit = 1'b1;
    @(posedge clk);
    #2;
    man_bereit = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    pruefe("t5_no_fertig", 32'(fertig_zahl), 32'(n_f));
    pruefe("t5_idle", {31'd0, Beschaeftigt}, 32'd0);
    ram_an = 1'b1;
    op("t5_lw", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

    // T6: Start held during a busy store is ignored
    ram_wait = 3;
    n_sch = sch_zahl;
    n_f   = fertig_zahl;
    zugriff("t6_sw", 1'b1, 2'b10, 1'b0, 32'hC, 32'h1234_5678, 32'h0, 1'b0, 6, 1'b1);
    Schreiben = 1'b1; Breite = 2'b10; CpuAdresse = 32'h10; CpuDatenRein = 32'hCAFE_F00D;
    Start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    Start = 1'b0;
    warte("t6_sw");
    repeat (6) @(posedge clk);
    #2;
    pruefe("t6_writes", 32'(sch_zahl), 32'(n_sch + 1));
    pruefe("t6_fertig", 32'(fertig_zahl), 32'(n_f + 1));
    pruefe("t6_mem3", mem[3], 32'h1234_5678);
    pruefe("t6_mem4", mem[4], 32'h0);
    ram_wait = 0;

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
